balance_mlp_seq: RTL
====================

# balance_mlp_seq

Time-multiplexed sequencer for the 4-4-bit-input / 3-hidden / 3-output Balance Scale MLP. It runs the network on one shared shift-based MAC and one accumulator, scheduling 12 layer-0 MAC steps and 9 layer-1 MAC steps per classification. It replaces the fully-parallel combinational classifier where area matters more than latency. The block sits between a valid/ready input stream of feature vectors and a valid/ready stream of class indices. Argmax is exact, not approximate.

## Interface
- IN_W, 4, bits per input feature (4 features packed)
- HID_W, 8, hidden activation width after ReLU/saturation
- ACC_W, 18, signed accumulator width
- CNT_W, 16, completed-classification counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  feature vector offered
- in_ready  out  1  block can accept (high only in IDLE)
- in_data  in  16  feature i at bits [4i+3:4i], unsigned
- out_valid  out  1  class result held
- out_ready  in  1  consumer accepts result
- out_class  out  2  argmax index 0..2
- busy  out  1  high in L0, L1 or DONE
- done_cnt  out  CNT_W  completed output handshakes, wraps modulo 2^CNT_W

## Operation
- Constants, hard-wired. L0 weights W0[n][i] = {64,64,-64,-64}, {64,64,-64,-64}, {-32,0,-4,-32}. L0 biases (scaled) = {16, 1024, -512}.
- L1 weights W1[o][n] = {-32,32,32}, {16,64,0}, {64,-64,32}. L1 biases (scaled) = {-4096, -4096, 4096}.
- Every weight is ±2^k or 0. The product is a shift of the operand; negative weights subtract. No multiplier is permitted.
- FSM states: IDLE, L0, L1, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready, register in_data, clear the step counters, load the accumulator with L0 bias[0], and go to L0.
- L0: one MAC per cycle over (n, i), n-major.
  - Last input of neuron n: h[n] = 0 if (acc + product) < 0, else min((acc + product) >> 4, 255). Store h[n] and load the accumulator with the next neuron's bias.
  - After n = 2, i = 3: load L1 bias[0] and go to L1.
  - Neuron 2 is processed normally; its result is always 0.
- L1: one MAC per cycle over (o, n), o-major, with operand h[n].
  - End of output o: score = ReLU(acc + product), 16-bit unsigned.
  - Running argmax: o = 0 initialises best. For o > 0, a score strictly greater than best replaces it. Ties keep the lower index.
  - After o = 2: out_class = best index, out_valid = 1, go to DONE.
- DONE: out_valid and out_class are held stable. On out_valid & out_ready: done_cnt += 1, out_valid = 0, go to IDLE.
- in_valid outside IDLE is ignored. in_data changes after acceptance have no effect.
- Arithmetic:
  - All sums are computed in ACC_W signed; no overflow is reachable (L0 max 1936, L1 range within ±12800).
  - Hidden saturation to 255 is implemented even though the trained weights never reach it.

## Timing
- Reset values: in_ready = 1 (IDLE), out_valid = 0, out_class = 0, busy = 0, done_cnt = 0, accumulator and h[] = 0.
- rst has priority over every event. It is sampled on the clock edge, and the next cycle is IDLE with all outputs at reset values. A transaction interrupted mid-L0/L1 or held in DONE is discarded, and done_cnt is not incremented.
- Latency: with acceptance at edge E0, edges E1..E12 perform the L0 steps and E13..E21 perform the L1 steps. out_valid is high from E21.
  - This gives exactly 21 cycles from acceptance to out_valid.
- The output handshake at edge Ek puts the block in IDLE after Ek; in_ready is high in the following cycle.
  - Minimum period is 23 cycles per classification when out_ready is tied high.
- No combinational path from in_valid or out_ready to any output.

## Test plan
- in_data = 16'h0000, out_ready = 1 -> h = {1,64,0}, scores {0,16,64}, out_class = 2, out_valid exactly 21 cycles after acceptance, done_cnt = 1.
- f0 = 15, f1 = 15, f2 = 0, f3 = 0 (16'h00FF) -> h = {121,184,0}, scores {0,9616,64}, out_class = 1.
- f0 = 0, f1 = 0, f2 = 15, f3 = 15 (16'hFF00) -> h = {0,0,0}, scores {0,0,4096}, out_class = 2. Also drive 16'h5555 -> out_class = 2 (balanced, same as zeros).
- Backpressure: out_ready = 0 for 5 cycles after out_valid, with in_valid = 1 and changing in_data -> out_class is stable, in_ready = 0, nothing accepted. Raising out_ready -> a single handshake, done_cnt increments by 1, and in_ready = 1 the next cycle.
- Assert rst for 1 cycle at E10 of a transaction -> next cycle in_ready = 1, out_valid = 0, done_cnt unchanged. A fresh 16'h00FF then yields out_class = 1 at 21 cycles.
- Three back-to-back transactions with out_ready = 1 -> acceptances 23 cycles apart, done_cnt = 3. A random 200-vector sweep must match a bit-exact golden model of the spec arithmetic.

Source files
------------

// File: rtl/balance_mlp_seq.sv
// Time-multiplexed Balance Scale MLP (4-3-3): one shift-only MAC and one accumulator,
// 12 layer-0 steps then 9 layer-1 steps per classification, exact running argmax.
module balance_mlp_seq #(
  parameter int IN_W  = 4,
  parameter int HID_W = 8,
  parameter int ACC_W = 18,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*IN_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_class,
  output logic               busy,
  output logic [CNT_W-1:0]   done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L0   = 2'd1,
    L1   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                   state;
  logic [4*IN_W-1:0]        data_q;
  logic [1:0]               idx_a;
  logic [1:0]               idx_b;
  logic signed [ACC_W-1:0]  acc;
  logic [HID_W-1:0]         h0, h1, h2;
  logic [15:0]              best_score;
  logic [1:0]               best_idx;

  logic [HID_W-1:0]         opnd;
  logic [4:0]               wcode;
  logic signed [ACC_W-1:0]  mag;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  sum;
  logic [HID_W-1:0]         h_new;
  logic [15:0]              score;
  logic                     take;

  // Weight code {zero, negate, shift[2:0]}: every weight is 0 or +/-2^shift.
  function automatic logic [4:0] w0_code(input logic [1:0] n, input logic [1:0] i);
    case ({n, i})
      4'b00_00, 4'b00_01, 4'b01_00, 4'b01_01: w0_code = 5'b0_0_110;
      4'b00_10, 4'b00_11, 4'b01_10, 4'b01_11: w0_code = 5'b0_1_110;
      4'b10_00, 4'b10_11:                     w0_code = 5'b0_1_101;
      4'b10_10:                               w0_code = 5'b0_1_010;
      default:                                w0_code = 5'b1_0_000;
    endcase
  endfunction

  function automatic logic [4:0] w1_code(input logic [1:0] o, input logic [1:0] n);
    case ({o, n})
      4'b00_00: w1_code = 5'b0_1_101;
      4'b00_01: w1_code = 5'b0_0_101;
      4'b00_10: w1_code = 5'b0_0_101;
      4'b01_00: w1_code = 5'b0_0_100;
      4'b01_01: w1_code = 5'b0_0_110;
      4'b10_00: w1_code = 5'b0_0_110;
      4'b10_01: w1_code = 5'b0_1_110;
      4'b10_10: w1_code = 5'b0_0_101;
      default:  w1_code = 5'b1_0_000;
    endcase
  endfunction

  function automatic logic signed [ACC_W-1:0] bias0(input logic [1:0] n);
    case (n)
      2'd0:    bias0 = ACC_W'(16);
      2'd1:    bias0 = ACC_W'(1024);
      default: bias0 = ACC_W'(-512);
    endcase
  endfunction

  function automatic logic signed [ACC_W-1:0] bias1(input logic [1:0] o);
    case (o)
      2'd0:    bias1 = ACC_W'(-4096);
      2'd1:    bias1 = ACC_W'(-4096);
      default: bias1 = ACC_W'(4096);
    endcase
  endfunction

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    opnd = '0;
    if (state == L1) begin
      case (idx_b)
        2'd0:    opnd = h0;
        2'd1:    opnd = h1;
        default: opnd = h2;
      endcase
    end else begin
      case (idx_b)
        2'd0:    opnd = HID_W'(data_q[IN_W-1:0]);
        2'd1:    opnd = HID_W'(data_q[2*IN_W-1:IN_W]);
        2'd2:    opnd = HID_W'(data_q[3*IN_W-1:2*IN_W]);
        default: opnd = HID_W'(data_q[4*IN_W-1:3*IN_W]);
      endcase
    end
  end

  always_comb begin
    wcode = (state == L1) ? w1_code(idx_a, idx_b) : w0_code(idx_a, idx_b);
    mag   = signed'(ACC_W'(opnd) << wcode[2:0]);
    term  = '0;
    if (!wcode[4]) begin
      term = wcode[3] ? -mag : mag;
    end
    sum = acc + term;
  end

  always_comb begin
    h_new = '0;
    if (!sum[ACC_W-1]) begin
      if (|sum[ACC_W-1:HID_W+4]) begin
        h_new = '1;
      end else begin
        h_new = sum[HID_W+3:4];
      end
    end
    score = sum[ACC_W-1] ? '0 : sum[15:0];
    take  = (idx_a == 2'd0) || (score > best_score);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_q     <= '0;
      idx_a      <= '0;
      idx_b      <= '0;
      acc        <= '0;
      h0         <= '0;
      h1         <= '0;
      h2         <= '0;
      best_score <= '0;
      best_idx   <= '0;
      out_class  <= '0;
      done_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            idx_a  <= '0;
            idx_b  <= '0;
            acc    <= bias0(2'd0);
            state  <= L0;
          end
        end
        L0: begin
          if (idx_b == 2'd3) begin
            case (idx_a)
              2'd0:    h0 <= h_new;
              2'd1:    h1 <= h_new;
              default: h2 <= h_new;
            endcase
            idx_b <= '0;
            if (idx_a == 2'd2) begin
              idx_a <= '0;
              acc   <= bias1(2'd0);
              state <= L1;
            end else begin
              idx_a <= idx_a + 2'd1;
              acc   <= bias0(idx_a + 2'd1);
            end
          end else begin
            acc   <= sum;
            idx_b <= idx_b + 2'd1;
          end
        end
        L1: begin
          if (idx_b == 2'd2) begin
            if (take) begin
              best_score <= score;
              best_idx   <= idx_a;
            end
            idx_b <= '0;
            if (idx_a == 2'd2) begin
              // final compare is folded in here so the result lands on the same edge
              out_class <= take ? idx_a : best_idx;
              idx_a     <= '0;
              state     <= DONE;
            end else begin
              idx_a <= idx_a + 2'd1;
              acc   <= bias1(idx_a + 2'd1);
            end
          end else begin
            acc   <= sum;
            idx_b <= idx_b + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            done_cnt <= done_cnt + CNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
